// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter (uart_tx_arb).
package uart_arb_pkg;

  localparam int BYTE_W        = 8;
  localparam int TO_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // Successor of idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and UART-transmitter signals of the arbiter; slave = arbiter side.
interface uart_tx_arb_if #(parameter int NREQ = 4);
  import uart_arb_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*BYTE_W-1:0] din;
  logic [NREQ-1:0]        ack;
  logic [IDW-1:0]         gnt_id;
  logic                   busy;
  logic [BYTE_W-1:0]      dintx;
  logic                   newd;
  logic                   donetx;

  modport master (output req, din, donetx, input ack, gnt_id, busy, dintx, newd);
  modport slave  (input req, din, donetx, output ack, gnt_id, busy, dintx, newd);
endinterface

// File: rtl/uart_tx_arb_rr_arb.sv
// Combinational round-robin picker: highest priority at ptr, then ascending with wrap.
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);
  localparam int IDW = $clog2(NREQ);

  logic           found_s;
  logic [IDW-1:0] cand_s;

  // Scan candidates starting at the pointer; the first pending request wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDW'((32'(ptr) + 32'(k)) % 32'(NREQ));
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from NREQ byte requesters.
// Optional donetx watchdog with sticky timeout_err: define UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TO_CYCLES = TO_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_arb_if.slave bus
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);
  localparam int IDW = $clog2(NREQ);

  arb_state_t        state_r, next_s;
  logic [IDW-1:0]    ptr_r, ptr_s, gnt_id_r, gnt_id_s, win_idx_s;
  logic [NREQ-1:0]   win_gnt_s, ack_r, ack_s;
  logic [BYTE_W-1:0] dintx_r, dintx_s, sel_byte_s;
  logic              newd_r, newd_s, busy_r, busy_s;
  logic              done_s;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req (bus.req),
    .ptr (ptr_r),
    .gnt (win_gnt_s),
    .idx (win_idx_s)
  );

  // Byte of the current round-robin winner (AND-OR mux on the one-hot grant).
  always_comb begin
    sel_byte_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_gnt_s[i]) begin
        sel_byte_s = sel_byte_s | bus.din[i*BYTE_W +: BYTE_W];
      end else begin
        sel_byte_s = sel_byte_s;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] to_cnt_r;
  logic          to_hit_s, timeout_err_r;

  assign to_hit_s = (state_r == BUSY) && (to_cnt_r == CW'(TO_CYCLES - 1));
  assign done_s   = bus.donetx || to_hit_s;

  // Watchdog counter: cleared while entering BUSY, counts every BUSY cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_r <= '0;
    end else if (state_r == LOAD) begin
      to_cnt_r <= '0;
    end else if (state_r == BUSY) begin
      to_cnt_r <= to_cnt_r + CW'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_err_r | to_hit_s;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign done_s = bus.donetx;
`endif

  // State and registered-output update; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      gnt_id_r <= '0;
      dintx_r  <= '0;
      newd_r   <= 1'b0;
      ack_r    <= '0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= next_s;
      ptr_r    <= ptr_s;
      gnt_id_r <= gnt_id_s;
      dintx_r  <= dintx_s;
      newd_r   <= newd_s;
      ack_r    <= ack_s;
      busy_r   <= busy_s;
    end
  end

  // Next-state logic; donetx only matters in BUSY.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|bus.req) next_s = LOAD;
        else          next_s = IDLE;
      end
      LOAD: next_s = BUSY;
      BUSY: begin
        if (done_s) next_s = DONE;
        else        next_s = BUSY;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Next values of the outputs, registered so each pulse lines up with its state.
  always_comb begin
    gnt_id_s = gnt_id_r;
    dintx_s  = dintx_r;
    ptr_s    = ptr_r;
    ack_s    = '0;
    newd_s   = 1'b0;
    busy_s   = (next_s != IDLE);
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          gnt_id_s = win_idx_s;
          dintx_s  = sel_byte_s;
          newd_s   = 1'b1;
        end else begin
          newd_s = 1'b0;
        end
      end
      LOAD: newd_s = 1'b0;
      BUSY: begin
        if (done_s) ack_s[gnt_id_r] = 1'b1;
        else        ack_s = '0;
      end
      DONE:    ptr_s = IDW'(rr_next(32'(gnt_id_r), NREQ));
      default: ack_s = '0;
    endcase
  end

  assign bus.ack    = ack_r;
  assign bus.gnt_id = gnt_id_r;
  assign bus.busy   = busy_r;
  assign bus.dintx  = dintx_r;
  assign bus.newd   = newd_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: vector table, corner sequences and a scoreboard.
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int NREQ = 4;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = TO_CYCLES_DEF;
`endif
  localparam int W_NEWD = 0;
  localparam int W_ACK  = 1;
  localparam int W_DONE = 2;

  typedef struct { int id; logic [7:0] data; } exp_t;
  typedef struct { logic [3:0] req; int exp_id; } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   cyc = 0;
  int   last_newd = -1;
  int   uart_delay = 3;
  bit   uart_en = 1'b1;
  int   u_cnt;
  bit   u_act;
  vec_t tbl[11];
  int   ord[5];

  always #5 clk = ~clk;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .TO_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h, expected no such event", name, act);
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_for(input int which, input string name);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < 400 && !hit; t++) begin
      @(negedge clk);
      case (which)
        W_NEWD:  hit = bus.newd;
        W_ACK:   hit = (bus.ack != '0);
        default: hit = bus.donetx;
      endcase
    end
    if (!hit) fail_now({name, "_timeout"}, 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Simple UART transmitter model: donetx pulses uart_delay cycles after newd.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_act <= 1'b0;
      u_cnt <= 0;
      bus.donetx <= 1'b0;
    end else begin
      bus.donetx <= 1'b0;
      if (uart_en && bus.newd) begin
        u_act <= 1'b1;
        u_cnt <= 0;
      end else if (u_act) begin
        if (u_cnt >= uart_delay - 1) begin
          bus.donetx <= 1'b1;
          u_act <= 1'b0;
        end else begin
          u_cnt <= u_cnt + 1;
        end
      end
    end
  end

  // Scoreboard: newd pops the next expected grant, ack must match it.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.newd) begin
        if (last_newd >= 0) chk("newd_gap_ge4", 32'(cyc - last_newd >= 4), 32'd1);
        last_newd = cyc;
        if (exp_q.size() == 0) begin
          fail_now("newd_unexpected", 32'(bus.gnt_id));
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          chk("sb_gnt_id", 32'(bus.gnt_id), 32'(cur.id));
          chk("sb_dintx", 32'(bus.dintx), 32'(cur.data));
        end
      end
      if (bus.ack != '0) begin
        if (!have_cur) begin
          fail_now("ack_unexpected", 32'(bus.ack));
        end else begin
          chk("sb_ack", 32'(bus.ack), 32'd1 << cur.id);
          chk("sb_dintx_done", 32'(bus.dintx), 32'(cur.data));
          have_cur = 1'b0;
        end
      end
    end
  end

  initial begin
    int seen;
    int n;
    // Vectors applied in sequence after the first 0001 transfer (pointer starts at 1).
    tbl[0]  = '{4'b0001, 0};
    tbl[1]  = '{4'b0110, 1};
    tbl[2]  = '{4'b0011, 0};
    tbl[3]  = '{4'b1000, 3};
    tbl[4]  = '{4'b1010, 1};
    tbl[5]  = '{4'b1100, 2};
    tbl[6]  = '{4'b1001, 3};
    tbl[7]  = '{4'b1001, 0};
    tbl[8]  = '{4'b1111, 1};
    tbl[9]  = '{4'b0101, 2};
    tbl[10] = '{4'b0111, 0};
    ord = '{0, 1, 2, 3, 0};

    bus.req = '0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("rst_dintx", 32'(bus.dintx), 32'd0);
    chk("rst_newd", 32'(bus.newd), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single request: newd one cycle after req, ack one cycle after donetx.
    bus.din[7:0] = 8'hA5;
    push_exp(0, 8'hA5);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("lat_newd", 32'(bus.newd), 32'd1);
    chk("lat_busy", 32'(bus.busy), 32'd1);
    wait_for(W_DONE, "lat_donetx");
    @(negedge clk);
    chk("ack_after_donetx", 32'(bus.ack), 32'b0001);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Table of round-robin vectors with varying UART frame lengths.
    for (int k = 0; k < 11; k++) begin
      uart_delay = 1 + (k % 4);
      for (int i = 0; i < NREQ; i++) bus.din[i*8 +: 8] = 8'(k * 16 + i + 1);
      push_exp(tbl[k].exp_id, 8'(k * 16 + tbl[k].exp_id + 1));
      bus.req = tbl[k].req;
      wait_for(W_ACK, "tbl_ack");
      chk("tbl_gnt_id", 32'(bus.gnt_id), 32'(tbl[k].exp_id));
      bus.req = '0;
      repeat (2) @(negedge clk);
      chk("tbl_idle", 32'(bus.busy), 32'd0);
    end

    // Requester 1 drops req and changes din mid-transfer.
    uart_delay = 8;
    bus.din[15:8] = 8'h5A;
    push_exp(1, 8'h5A);
    bus.req = 4'b0010;
    wait_for(W_NEWD, "drop_newd");
    repeat (2) @(negedge clk);
    bus.req[1] = 1'b0;
    bus.din[15:8] = 8'hFF;
    @(negedge clk);
    chk("drop_dintx_hold", 32'(bus.dintx), 32'h5A);
    chk("drop_busy", 32'(bus.busy), 32'd1);
    wait_for(W_ACK, "drop_ack");
    chk("drop_ack_bit", 32'(bus.ack), 32'b0010);
    repeat (2) @(negedge clk);

    // Reset asserted in BUSY aborts the transfer.
    bus.din[23:16] = 8'h77;
    push_exp(2, 8'h77);
    bus.req = 4'b0100;
    wait_for(W_NEWD, "rst_mid_newd");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(bus.ack), 32'd0);
    chk("rst_mid_newd", 32'(bus.newd), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_dintx", 32'(bus.dintx), 32'd0);
    chk("rst_mid_gnt_id", 32'(bus.gnt_id), 32'd0);
    have_cur = 1'b0;
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.ack != '0) seen++;
    end
    chk("no_ack_after_rst", 32'(seen), 32'd0);
    uart_delay = 3;
    bus.din = 32'hC4C3C2C1;
    push_exp(0, 8'hC1);
    bus.req = 4'b1111;
    wait_for(W_ACK, "post_rst_ack");
    chk("post_rst_gnt0", 32'(bus.gnt_id), 32'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // All four requesters held: order 0,1,2,3,0 from a fresh reset.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.din = 32'h44332211;
    for (int j = 0; j < 5; j++) push_exp(ord[j], 8'(8'h11 * (ord[j] + 1)));
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_for(W_ACK, "hold_ack");
      chk("hold_order", 32'(bus.gnt_id), 32'(ord[j]));
    end
    bus.req = '0;
    repeat (2) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
    // donetx never arrives: watchdog fires after 64 BUSY cycles.
    uart_en = 1'b0;
    bus.din[7:0] = 8'h3C;
    push_exp(0, 8'h3C);
    bus.req = 4'b0001;
    wait_for(W_NEWD, "to_newd");
    chk("to_err_before", 32'(timeout_err), 32'd0);
    n = 0;
    for (int t = 1; t <= 200 && n == 0; t++) begin
      @(negedge clk);
      if (timeout_err) n = t;
    end
    chk("to_cycle", 32'(n), 32'd65);
    chk("to_ack", 32'(bus.ack), 32'b0001);
    bus.req = '0;
    @(negedge clk);
    chk("to_idle", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    uart_en = 1'b1;
`else
    n = 0;
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
